// File: rtl/axilite_regfile_slave.sv
// axilite_regfile_slave
//
// AXI-Lite responder exposing a bank of 32-bit control/status registers.
// Indices 0..NUM_REGS-2 are read/write; index NUM_REGS-1 is a read-only
// ID register that always returns ID_VALUE. Accesses to the ID register
// (writes only) and to any index >= NUM_REGS complete with SLVERR.
//
// The write address and write data channels are buffered independently,
// so AW and W may arrive in either order or in the same cycle. The
// register update happens on the edge after both buffers are full, and
// the write response is raised on that same edge.
//
// Ports
//   aclk, areset      clock (rising edge), asynchronous active-high reset
//   aw*/w*/b*         AXI-Lite write address / data / response channels
//   ar*/r*            AXI-Lite read address / data channels
//   regs_o            flattened register contents, reg i at [i*32 +: 32]
//   wr_pulse_o        bit i pulses for one cycle after reg i is written

module axilite_regfile_slave #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA11E_0001
) (
  input  logic                             aclk,
  input  logic                             areset,

  input  logic [ADDR_WIDTH-1:0]            awaddr,
  input  logic                             awvalid,
  output logic                             awready,

  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/8-1:0]          wstrb,
  input  logic                             wvalid,
  output logic                             wready,

  output logic [1:0]                       bresp,
  output logic                             bvalid,
  input  logic                             bready,

  input  logic [ADDR_WIDTH-1:0]            araddr,
  input  logic                             arvalid,
  output logic                             arready,

  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [1:0]                       rresp,
  output logic                             rvalid,
  input  logic                             rready,

  output logic [NUM_REGS*DATA_WIDTH-1:0]   regs_o,
  output logic [NUM_REGS-1:0]              wr_pulse_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int RIDX_W = $clog2(NUM_REGS);

  // Word index of the read-only ID register; anything below it is writable.
  localparam logic [IDX_W-1:0] ID_IDX = IDX_W'(NUM_REGS - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Writable register storage (the ID register has no storage).
  logic [DATA_WIDTH-1:0] regs [0:NUM_REGS-2];

  // Write-side buffers
  logic                  aw_full;
  logic [IDX_W-1:0]      aw_idx;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;

  // Read-side decode
  logic [IDX_W-1:0]      ar_idx;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [1:0]            rd_resp_mux;

  // Byte-lane offset bits are never decoded.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

  // Ready outputs are held low for the whole reset assertion. A pending
  // write response blocks both write channels so at most one write is in
  // flight at a time.
  assign awready = !aw_full && !bvalid && !areset;
  assign wready  = !w_full  && !bvalid && !areset;
  assign arready = !rvalid  && !areset;

  // --------------------------------------------------------------------
  // Write path: buffers, commit, response
  // --------------------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_full    <= 1'b0;
      aw_idx     <= '0;
      w_full     <= 1'b0;
      w_data     <= '0;
      w_strb     <= '0;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
      wr_pulse_o <= '0;
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        regs[i] <= '0;
      end
    end else begin
      wr_pulse_o <= '0;

      if (awvalid && awready) begin
        aw_full <= 1'b1;
        aw_idx  <= awaddr[ADDR_WIDTH-1:2];
      end

      if (wvalid && wready) begin
        w_full <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end

      // Both buffers full: commit. The readys are low while either buffer
      // is full, so no new handshake can coincide with a commit.
      if (aw_full && w_full) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        if (aw_idx < ID_IDX) begin
          bresp <= RESP_OKAY;
          for (int k = 0; k < STRB_W; k++) begin
            if (w_strb[k]) begin
              regs[aw_idx[RIDX_W-1:0]][k*8 +: 8] <= w_data[k*8 +: 8];
            end
          end
          // Pulses even with an all-zero strobe: the write was accepted.
          wr_pulse_o[aw_idx[RIDX_W-1:0]] <= 1'b1;
        end else begin
          bresp <= RESP_SLVERR;
        end
      end

      if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------
  always_comb begin
    ar_idx      = araddr[ADDR_WIDTH-1:2];
    rd_mux      = '0;
    rd_resp_mux = RESP_SLVERR;
    if (ar_idx < ID_IDX) begin
      rd_mux      = regs[ar_idx[RIDX_W-1:0]];
      rd_resp_mux = RESP_OKAY;
    end else if (ar_idx == ID_IDX) begin
      rd_mux      = ID_VALUE;
      rd_resp_mux = RESP_OKAY;
    end
  end

  // Captures the register value as it stands before the edge, so a read
  // coinciding with a commit to the same register returns the old value.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else begin
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= rd_mux;
        rresp  <= rd_resp_mux;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------
  // Flattened register view; the ID slot carries its constant.
  // --------------------------------------------------------------------
  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
    regs_o[(NUM_REGS-1)*DATA_WIDTH +: DATA_WIDTH] = ID_VALUE;
  end

endmodule

// File: tb/tb_axilite_regfile_slave.sv
// tb_axilite_regfile_slave
//
// Self-checking bench for axilite_regfile_slave: a table of directed
// read/write vectors with hand-computed expectations, followed by
// hand-written sequences for early W, B back-pressure with concurrent
// reads, and reset in the middle of a transaction.

module tb_axilite_regfile_slave;

  localparam logic [31:0] ID_VAL = 32'hA11E_0001;

  logic         aclk = 1'b0;
  logic         areset;
  logic [9:0]   awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [9:0]   araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [511:0] regs_o;
  logic [15:0]  wr_pulse_o;

  always #5 aclk = ~aclk;

  axilite_regfile_slave dut (
    .aclk       (aclk),
    .areset     (areset),
    .awaddr     (awaddr),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wvalid     (wvalid),
    .wready     (wready),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_val;
    logic [1:0]  exp_resp;
    logic [15:0] exp_pulse;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Write with AW and W presented together and bready high.
  task automatic do_write(input string tag, input logic [9:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [31:0] exp_val,
                          input logic [1:0] exp_resp, input logic [15:0] exp_pulse);
    logic [479:0] exp_regs;
    int idx;
    int n;
    bit hs_aw, hs_w;
    exp_regs = regs_o[479:0];
    idx = int'(addr[9:2]);
    if (exp_resp == 2'b00 && idx < 15) exp_regs[idx*32 +: 32] = exp_val;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick();
      if (hs_aw) awvalid = 1'b0;
      if (hs_w)  wvalid  = 1'b0;
      n++;
    end
    check($sformatf("%s_hs_pending", tag), {awvalid, wvalid}, 0);
    awvalid = 1'b0; wvalid = 1'b0;
    check($sformatf("%s_bvalid_early", tag), bvalid, 0);
    tick();
    check($sformatf("%s_bvalid", tag), bvalid, 1);
    check($sformatf("%s_bresp", tag), bresp, exp_resp);
    check($sformatf("%s_pulse", tag), wr_pulse_o, exp_pulse);
    check($sformatf("%s_regs", tag), regs_o[479:0], exp_regs);
    tick();
    check($sformatf("%s_bvalid_drop", tag), bvalid, 0);
    check($sformatf("%s_pulse_drop", tag), wr_pulse_o, 0);
  endtask

  // Read with rready high; rvalid must appear exactly one cycle after AR.
  task automatic do_read(input string tag, input logic [9:0] addr,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n;
    araddr = addr;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("%s_arready", tag), arready, 1);
    tick();
    arvalid = 1'b0;
    check($sformatf("%s_rvalid", tag), rvalid, 1);
    check($sformatf("%s_rdata", tag), rdata, exp_data);
    check($sformatf("%s_rresp", tag), rresp, exp_resp);
    tick();
    check($sformatf("%s_rvalid_drop", tag), rvalid, 0);
  endtask

  task automatic add_vec(input bit wr, input logic [9:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [31:0] exp_val,
                         input logic [1:0] exp_resp, input logic [15:0] exp_pulse);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
    v.exp_val = exp_val; v.exp_resp = exp_resp; v.exp_pulse = exp_pulse;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    // ------------------------------------------------------------------
    // Vector table (expected values computed by hand)
    // ------------------------------------------------------------------
    for (int i = 0; i < 16; i++) begin
      add_vec(0, 10'(i * 4), 0, 0, (i == 15) ? ID_VAL : 32'h0, 2'b00, 0);
    end
    add_vec(1, 10'h008, 32'h1122_3344, 4'hF, 32'h1122_3344, 2'b00, 16'h0004);
    add_vec(1, 10'h008, 32'hDEAD_BEEF, 4'b0101, 32'h11AD_33EF, 2'b00, 16'h0004);
    add_vec(0, 10'h008, 0, 0, 32'h11AD_33EF, 2'b00, 0);
    add_vec(0, 10'h00B, 0, 0, 32'h11AD_33EF, 2'b00, 0);
    add_vec(1, 10'h03C, 32'hFFFF_FFFF, 4'hF, 0, 2'b10, 16'h0000);
    add_vec(0, 10'h03C, 0, 0, ID_VAL, 2'b00, 0);
    add_vec(1, 10'h100, 32'h1234_5678, 4'hF, 0, 2'b10, 16'h0000);
    add_vec(0, 10'h100, 0, 0, 32'h0, 2'b10, 0);
    add_vec(0, 10'h3FC, 0, 0, 32'h0, 2'b10, 0);
    add_vec(1, 10'h010, 32'hFFFF_FFFF, 4'h0, 32'h0, 2'b00, 16'h0010);
    add_vec(0, 10'h010, 0, 0, 32'h0, 2'b00, 0);
    add_vec(1, 10'h03B, 32'h1234_5678, 4'hF, 32'h1234_5678, 2'b00, 16'h4000);
    add_vec(0, 10'h038, 0, 0, 32'h1234_5678, 2'b00, 0);
    add_vec(1, 10'h040, 32'h0000_AAAA, 4'hF, 0, 2'b10, 16'h0000);
    add_vec(0, 10'h040, 0, 0, 32'h0, 2'b10, 0);

    // ------------------------------------------------------------------
    // Reset state
    // ------------------------------------------------------------------
    areset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
    repeat (3) tick();
    check("rst_readys", {awready, wready, arready}, 3'b000);
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_resps", {bresp, rresp}, 4'b0000);
    check("rst_rdata", rdata, 0);
    check("rst_pulse", wr_pulse_o, 0);
    check("rst_regs", regs_o[479:0], 0);
    check("rst_id_slot", regs_o[511:480], ID_VAL);
    areset = 1'b0;
    #1;
    check("post_rst_readys", {awready, wready, arready}, 3'b111);
    tick();

    // ------------------------------------------------------------------
    // Table-driven vectors
    // ------------------------------------------------------------------
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr)
        do_write($sformatf("v%0d", i), vecs[i].addr, vecs[i].data, vecs[i].strb,
                 vecs[i].exp_val, vecs[i].exp_resp, vecs[i].exp_pulse);
      else
        do_read($sformatf("v%0d", i), vecs[i].addr, vecs[i].exp_val, vecs[i].exp_resp);
    end

    // ------------------------------------------------------------------
    // W three cycles ahead of AW
    // ------------------------------------------------------------------
    wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
    check("early_w_wready", wready, 1);
    tick();
    wvalid = 1'b0;
    check("early_w_wready_drop", wready, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("early_w_hold%0d", i), {wready, bvalid}, 2'b00);
    end
    awaddr = 10'h004; awvalid = 1'b1;
    check("early_w_awready", awready, 1);
    tick();
    awvalid = 1'b0;
    check("early_w_bvalid_early", bvalid, 0);
    tick();
    check("early_w_bvalid", bvalid, 1);
    check("early_w_bresp", bresp, 2'b00);
    check("early_w_reg1", regs_o[63:32], 32'h5);
    check("early_w_pulse", wr_pulse_o, 16'h0002);
    tick();
    check("early_w_bvalid_drop", bvalid, 0);

    // ------------------------------------------------------------------
    // bready low for 10 cycles while reads keep flowing
    // ------------------------------------------------------------------
    bready = 1'b0;
    awaddr = 10'h00C; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check("bp_bvalid", bvalid, 1);
    check("bp_reg3", regs_o[127:96], 32'hCAFE_F00D);
    araddr = 10'h008; arvalid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("bp_hold%0d", i), {bvalid, awready, wready}, 3'b100);
      if (rvalid) begin
        cnt++;
        check($sformatf("bp_rdata%0d", i), rdata, 32'h11AD_33EF);
      end
    end
    arvalid = 1'b0;
    check("bp_read_count", cnt, 5);
    bready = 1'b1;
    tick();
    check("bp_bvalid_drop", bvalid, 0);
    check("bp_rvalid_idle", rvalid, 0);

    // ------------------------------------------------------------------
    // Reset with AW buffered and a read response pending
    // ------------------------------------------------------------------
    awaddr = 10'h018; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("mid_aw_buffered", awready, 0);
    rready = 1'b0;
    araddr = 10'h00C; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("mid_rvalid", rvalid, 1);
    #2;
    areset = 1'b1;
    #1;
    check("mid_rst_valids", {bvalid, rvalid}, 2'b00);
    check("mid_rst_regs", regs_o[479:0], 0);
    check("mid_rst_rdata", rdata, 0);
    tick();
    areset = 1'b0;
    rready = 1'b1;
    // W alone must not commit: the stale AW was discarded.
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_no_commit%0d", i), bvalid, 0);
    end
    awaddr = 10'h018; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("mid_bvalid_early", bvalid, 0);
    tick();
    check("mid_bvalid", bvalid, 1);
    check("mid_bresp", bresp, 2'b00);
    check("mid_reg6", regs_o[223:192], 32'h77);
    check("mid_pulse", wr_pulse_o, 16'h0040);
    tick();
    do_read("mid_rd6", 10'h018, 32'h77, 2'b00);
    do_read("mid_rd2", 10'h008, 32'h0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axilite_regfile_slave.md
# axilite_regfile_slave

Synthesizable AXI-Lite slave (responder) exposing a bank of 32-bit control/status registers to an AXI-Lite master. It occupies the DUT position between the master-side and slave-side `axilite_if` instances and is driven by the `axilite_agent` in `MASTER_AGENT` mode. Write address and write data channels are buffered independently, byte strobes are honoured, and out-of-range or read-only accesses complete with SLVERR.

## Interface

- ADDR_WIDTH, 10, byte address width; word index = addr[ADDR_WIDTH-1:2]
- DATA_WIDTH, 32, data width; fixed at 32 (4 strobe bits)
- NUM_REGS, 16, register count; index NUM_REGS-1 is the read-only ID register
- ID_VALUE, 32'hA11E_0001, constant returned by the ID register
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- awaddr  in  ADDR_WIDTH  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  ADDR_WIDTH  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rvalid  out  1  read response valid
- rready  in  1  read response ready
- regs_o  out  NUM_REGS*DATA_WIDTH  flattened register contents; reg i at [i*32 +: 32]
- wr_pulse_o  out  NUM_REGS  one-cycle pulse, bit i set on the cycle after reg i is written

## Operation

- Write path: AW buffer (addr, full flag), W buffer (data, strb, full flag), B stage (bvalid, bresp).
- awready = !aw_full && !bvalid && !areset; wready = !w_full && !bvalid && !areset. AW and W may arrive in either order or the same cycle.
- Commit: on an edge where aw_full && w_full, decode index; if index < NUM_REGS-1, update each byte k where wstrb[k]=1, bresp=OKAY; if index == NUM_REGS-1 or index >= NUM_REGS, no register change, bresp=SLVERR. Same edge: bvalid<=1, both buffers cleared, wr_pulse_o bit set only for a successful write (even if wstrb=0).
- bvalid holds, bresp stable, until bready sampled high; then bvalid<=0.
- addr[1:0] ignored throughout.
- Read path: arready = !rvalid && !areset. On AR handshake, rdata<=reg[index] (ID_VALUE for NUM_REGS-1, 0 and SLVERR for index >= NUM_REGS), rresp set, rvalid<=1. rdata/rresp hold until rready; then rvalid<=0.
- Read and write paths are independent; a read and a commit to the same register on the same edge return the pre-write value.

## Timing

- Reset (async assert): all registers 0, buffers empty, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, wr_pulse_o=0; all ready outputs 0 while areset high, 1 on the first cycle after deassertion.
- Write latency: AW and W handshakes in cycle N -> commit edge end of N+1 -> bvalid high in cycle N+2. If W arrives K cycles after AW, bvalid is high K cycles later.
- regs_o reflects the new value in the same cycle bvalid first rises; wr_pulse_o high for exactly that cycle.
- With bready tied high, write throughput is one transaction per 3 cycles; the next AW/W is accepted the cycle after the B handshake.
- Read latency: AR handshake in cycle N -> rvalid in N+1. With rready high, rvalid drops in N+2 and arready returns in N+2: one read per 2 cycles.
- Back-pressure: holding bready or rready low stalls only that path; the other path keeps running.
- Reset mid-transaction: buffered AW/W and pending B/R responses are discarded; no partial register write.

## Test plan

- Reset then read all 16 indices -> rdata 0 with OKAY for 0..14, 32'hA11E_0001 with OKAY for 15; rvalid exactly 1 cycle after each AR handshake.
- Write 0xDEADBEEF to addr 0x008 with wstrb=4'b0101, reg previously 0x11223344 -> reg 2 = 0x11AD33EF, bresp OKAY, wr_pulse_o[2] single-cycle pulse.
- W presented 3 cycles before AW (addr 0x004, data 0x5) -> wready drops after W handshake, bvalid 2 cycles after AW handshake, reg 1 = 0x5.
- Write to 0x03C (ID) and 0x100 (index 64) -> both bresp SLVERR, no wr_pulse_o, reg contents unchanged; read of 0x100 -> rdata 0, SLVERR.
- bready held low 10 cycles after a write -> bvalid stays high, awready/wready stay 0; concurrent reads still complete with 2-cycle throughput.
- Assert areset while AW buffered and rvalid high -> bvalid/rvalid 0 immediately, registers all 0, subsequent write/read complete normally.
